// File: rtl/uart_mem_loader.sv
// UART firmware loader: decodes a byte-stream command protocol received on
// uart_rx (8N1) and issues word writes on the native memory bus, keeping the
// CPU in reset until the DONE command arrives.
//   Commands: 0x01 a0 a1 a2 a3  set write address (LE, forced word-aligned)
//             0x02 n d0..d3 ... write n words (n=0 means 256), LE data
//             0x03              release cpu_hold; later bytes are ignored
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   uart_rx                asynchronous serial input, idle high
//   mem_valid/mem_ready    write handshake (ready is a one-cycle pulse)
//   mem_addr/mem_wdata     write address pointer / data word
//   mem_wstrb              4'hF while mem_valid, else 0
//   cpu_hold               1 keeps the CPU in reset
//   busy                   1 while a command is in progress
//   err                    sticky flags: [0] framing error, [1] overrun
// There is no timeout on mem_ready: a write to an address with no responder
// stalls the loader until resetn.
module uart_mem_loader #(
  parameter int unsigned CLK_DIV   = 26,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        cpu_hold,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_DONE
  } state_t;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit sequencer: rx_bit 0 = start, 1..8 = data (LSB first), 9 = stop
  logic          rx_active;
  logic [3:0]    rx_bit;
  logic [TW-1:0] rx_timer;
  logic [7:0]    rx_shift;
  logic          stop_tick, rx_good, frame_err;

  assign stop_tick = rx_active && (rx_timer == '0) && (rx_bit == 4'd9);
  assign rx_good   = stop_tick && rx_sync;
  assign frame_err = stop_tick && !rx_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_active <= 1'b0;
      rx_bit    <= '0;
      rx_timer  <= '0;
      rx_shift  <= '0;
    end else if (!rx_active) begin
      if (rx_prev && !rx_sync) begin
        rx_active <= 1'b1;
        rx_bit    <= '0;
        rx_timer  <= HALF_LAST;
      end
    end else if (rx_timer != '0) begin
      rx_timer <= rx_timer - TW'(1);
    end else begin
      rx_timer <= BIT_LAST;
      if (rx_bit == 4'd0) begin
        // start bit high at mid-bit: treat as a glitch
        if (rx_sync) rx_active <= 1'b0;
        else         rx_bit    <= 4'd1;
      end else if (rx_bit == 4'd9) begin
        rx_active <= 1'b0;
      end else begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 4'd1;
      end
    end
  end

  // Holding register and sticky error flags
  logic [7:0] hold_byte;
  logic       byte_rdy;
  logic       consume;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_byte <= '0;
      byte_rdy  <= 1'b0;
      err       <= '0;
    end else begin
      if (rx_good) begin
        hold_byte <= rx_shift;
        byte_rdy  <= 1'b1;
        if (byte_rdy && !consume) err[1] <= 1'b1;
      end else if (consume) begin
        byte_rdy <= 1'b0;
      end
      if (frame_err) err[0] <= 1'b1;
    end
  end

  // Command FSM and bus-side registers
  state_t      state, state_nxt;
  logic [31:0] addr_sr, addr_sr_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [8:0]  word_cnt, word_cnt_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]  mem_wstrb_nxt;
  logic        mem_valid_nxt, cpu_hold_nxt, busy_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      addr_sr   <= '0;
      byte_idx  <= '0;
      word_cnt  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_sr   <= addr_sr_nxt;
      byte_idx  <= byte_idx_nxt;
      word_cnt  <= word_cnt_nxt;
      mem_valid <= mem_valid_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_wstrb <= mem_wstrb_nxt;
      cpu_hold  <= cpu_hold_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (byte_rdy) begin
          case (hold_byte)
            8'h01:   state_nxt = S_ADDR;
            8'h02:   state_nxt = S_CNT;
            8'h03:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_ADDR:  if (byte_rdy && byte_idx == 2'd3) state_nxt = S_IDLE;
      S_CNT:   if (byte_rdy) state_nxt = S_DATA;
      S_DATA:  if (byte_rdy && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE: if (mem_ready) state_nxt = (word_cnt == 9'd1) ? S_IDLE : S_DATA;
      default: state_nxt = state;
    endcase
  end

  // Output and datapath logic; bytes wait in the holding register during WRITE
  always_comb begin
    consume       = byte_rdy && (state != S_WRITE);
    addr_sr_nxt   = addr_sr;
    byte_idx_nxt  = byte_idx;
    word_cnt_nxt  = word_cnt;
    mem_valid_nxt = mem_valid;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_wstrb_nxt = mem_wstrb;
    case (state)
      S_IDLE: byte_idx_nxt = '0;
      S_ADDR: begin
        if (byte_rdy) begin
          addr_sr_nxt  = {hold_byte, addr_sr[31:8]};
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) mem_addr_nxt = {hold_byte, addr_sr[31:10], 2'b00};
        end
      end
      S_CNT: begin
        if (byte_rdy) begin
          word_cnt_nxt = (hold_byte == 8'h00) ? 9'd256 : {1'b0, hold_byte};
          byte_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (byte_rdy) begin
          mem_wdata_nxt = {hold_byte, mem_wdata[31:8]};
          byte_idx_nxt  = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            mem_valid_nxt = 1'b1;
            mem_wstrb_nxt = 4'hF;
          end
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          mem_valid_nxt = 1'b0;
          mem_wstrb_nxt = 4'h0;
          mem_addr_nxt  = mem_addr + 32'd4;
          word_cnt_nxt  = word_cnt - 9'd1;
          byte_idx_nxt  = '0;
        end
      end
      default: ;
    endcase
    cpu_hold_nxt = (state_nxt != S_DONE);
    busy_nxt     = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
  end

endmodule
